// File: rtl/param_alu_seq.sv
// Sequential ALU: single-cycle add/sub/pass with optional saturation and a
// radix-2 shift-add signed multiplier. Optional macro: PARAM_ALU_MUL_ROUND_EN.
module param_alu_seq #(
    parameter int DW    = 16,
    parameter int SAT_W = 12,
    parameter int FRAC  = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [1:0]    shift,
    input  logic          sat_en,
    input  logic [DW-1:0] src1,
    input  logic [DW-1:0] src0,
    output logic [DW-1:0] dst,
    output logic          ovf,
    output logic          busy,
    output logic          done
);

    localparam int AW = DW + 3;
    localparam int PW = 2 * DW;
    localparam int RW = PW + 1;
    localparam int CW = $clog2(DW);

    localparam logic signed [AW-1:0] SAT_MAX = AW'((64'sd1 <<< (SAT_W - 1)) - 64'sd1);
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

`ifdef PARAM_ALU_MUL_ROUND_EN
    localparam logic [RW-1:0] RND = {{(RW-1){1'b0}}, 1'b1} << (FRAC - 1);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] dst_q, dst_d;
    logic          ovf_q, ovf_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [PW-1:0] acc_q, acc_d;
    logic [PW-1:0] mcand_q, mcand_d;
    logic [DW-1:0] mplier_q, mplier_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic signed [AW-1:0] src1_x, src0_x, src0_sh, sum;
    logic [DW:0]          alu_res, mul_res;
    logic [PW-1:0]        pp, acc_nx;
    logic                 last;

    // Returns {ovf, value}: clamp to the SAT_W range, or wrap to DW bits.
    function automatic logic [DW:0] sat_fn(input logic signed [AW-1:0] v, input logic en);
        logic [DW:0] r;
        if (en) begin
            if (v > SAT_MAX) begin
                r = {1'b1, SAT_MAX[DW-1:0]};
            end else if (v < SAT_MIN) begin
                r = {1'b1, SAT_MIN[DW-1:0]};
            end else begin
                r = {1'b0, v[DW-1:0]};
            end
        end else begin
            r = {~((&v[AW-1:DW-1]) | ~(|v[AW-1:DW-1])), v[DW-1:0]};
        end
        return r;
    endfunction

    // Returns {ovf, value}: scale the full product by 2^-FRAC and clamp to DW signed.
    function automatic logic [DW:0] mul_fn(input logic [PW-1:0] prod);
        logic signed [RW-1:0] p;
        logic signed [RW-1:0] s;
        logic [DW:0]          r;
        p = {prod[PW-1], prod};
`ifdef PARAM_ALU_MUL_ROUND_EN
        p = p + RND;
`else
        p = p;
`endif
        s = p >>> FRAC;
        if ((&s[RW-1:DW-1]) | ~(|s[RW-1:DW-1])) begin
            r = {1'b0, s[DW-1:0]};
        end else if (s[RW-1]) begin
            r = {1'b1, 1'b1, {(DW-1){1'b0}}};
        end else begin
            r = {1'b1, 1'b0, {(DW-1){1'b1}}};
        end
        return r;
    endfunction

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d  = state_q;
        dst_d    = dst_q;
        ovf_d    = ovf_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;

        src1_x = {{3{src1[DW-1]}}, src1};
        src0_x = {{3{src0[DW-1]}}, src0};
        case (shift)
            2'd1:    src0_sh = src0_x <<< 1;
            2'd2:    src0_sh = src0_x <<< 2;
            default: src0_sh = src0_x;
        endcase
        case (op)
            2'b00:   sum = src1_x + src0_sh;
            2'b01:   sum = src1_x - src0_sh;
            default: sum = src1_x;
        endcase
        alu_res = sat_fn(sum, sat_en);

        // The multiplier MSB carries negative weight, so the last partial product is subtracted.
        pp      = mplier_q[0] ? mcand_q : {PW{1'b0}};
        last    = (cnt_q == CW'(DW - 1));
        acc_nx  = last ? (acc_q - pp) : (acc_q + pp);
        mul_res = mul_fn(acc_nx);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op == 2'b10) begin
                        state_d  = MUL;
                        acc_d    = {PW{1'b0}};
                        mcand_d  = {{DW{src1[DW-1]}}, src1};
                        mplier_d = src0;
                        cnt_d    = {CW{1'b0}};
                    end else begin
                        state_d = DONE;
                        dst_d   = alu_res[DW-1:0];
                        ovf_d   = alu_res[DW];
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                acc_d    = acc_nx;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (last) begin
                    state_d = DONE;
                    dst_d   = mul_res[DW-1:0];
                    ovf_d   = mul_res[DW];
                end else begin
                    state_d = MUL;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            dst_q    <= {DW{1'b0}};
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            acc_q    <= {PW{1'b0}};
            mcand_q  <= {PW{1'b0}};
            mplier_q <= {DW{1'b0}};
            cnt_q    <= {CW{1'b0}};
        end else begin
            state_q  <= state_d;
            dst_q    <= dst_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dst  = dst_q;
    assign ovf  = ovf_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_param_alu_seq.sv
// Directed bench for param_alu_seq (DW=16, SAT_W=12, FRAC=12) with an
// expected-result queue and immediate assertions at each comparison.
module tb_param_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [1:0]  shift;
    logic        sat_en;
    logic [15:0] src1;
    logic [15:0] src0;
    logic [15:0] dst;
    logic        ovf;
    logic        busy;
    logic        done;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    param_alu_seq #(.DW(16), .SAT_W(12), .FRAC(12)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .shift  (shift),
        .sat_en (sat_en),
        .src1   (src1),
        .src0   (src0),
        .dst    (dst),
        .ovf    (ovf),
        .busy   (busy),
        .done   (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic using native integer multiply; returns {ovf, dst}.
    function automatic logic [16:0] model(input logic [1:0] o, input logic [1:0] sh,
                                          input logic se, input logic [15:0] a, input logic [15:0] b);
        longint x, y, r, w;
        logic   ov;
        x  = longint'($signed(a));
        y  = longint'($signed(b));
        ov = 1'b0;
        if (o == 2'b10) begin
            r = x * y;
`ifdef PARAM_ALU_MUL_ROUND_EN
            r = r + 2048;
`endif
            r = r >>> 12;
            if (r > 32767) begin r = 32767; ov = 1'b1; end
            else if (r < -32768) begin r = -32768; ov = 1'b1; end
        end else begin
            if (sh == 2'd1) y = y * 2;
            else if (sh == 2'd2) y = y * 4;
            r = (o == 2'b00) ? x + y : (o == 2'b01) ? x - y : x;
            if (se) begin
                if (r > 2047) begin r = 2047; ov = 1'b1; end
                else if (r < -2048) begin r = -2048; ov = 1'b1; end
            end else begin
                w  = longint'($signed(r[15:0]));
                ov = (w != r);
                r  = w;
            end
        end
        return {ov, r[15:0]};
    endfunction

    task automatic run_op(input string tag, input logic [1:0] o, input logic [1:0] sh,
                          input logic se, input logic [15:0] a, input logic [15:0] b,
                          input logic [16:0] exp, input int inj_at, input int rst_at);
        int          cyc;
        int          busy_cnt;
        int          lat;
        logic        seen_done;
        logic [16:0] e;
        @(negedge clk);
        op = o; shift = sh; sat_en = se; src1 = a; src0 = b; start = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        start = 1'b0; cyc = 1; busy_cnt = 0; seen_done = 1'b0;
        while (cyc <= 40) begin
            if (busy) busy_cnt++;
            if (done) begin seen_done = 1'b1; break; end
            if (cyc == 2) begin src1 = ~a; src0 = ~b; op = 2'b00; end
            if (cyc == inj_at) begin
                start = 1'b1; op = 2'b00; shift = 2'd0; sat_en = 1'b0;
                src1 = 16'h0001; src0 = 16'h0001;
            end else begin
                start = 1'b0;
            end
            rst = (cyc == rst_at) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        rst   = 1'b0;
        e = exp_q.pop_front();
        if (rst_at > 0) begin
            check({tag, "_nodone"}, 32'(seen_done), 32'd0);
            check({tag, "_dst"},    32'(dst),  32'h0000);
            check({tag, "_ovf"},    32'(ovf),  32'd0);
            check({tag, "_busy"},   32'(busy), 32'd0);
        end else begin
            lat = (o == 2'b10) ? 17 : 1;
            check({tag, "_dst"},  32'(dst), 32'(e[15:0]));
            check({tag, "_ovf"},  32'(ovf), 32'(e[16]));
            check({tag, "_lat"},  32'(cyc), 32'(lat));
            check({tag, "_busy"}, 32'(busy_cnt), 32'(lat));
            @(posedge clk); #1;
            check({tag, "_idle"}, 32'({busy, done}), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  ro, rs;
        logic        re;
        logic [15:0] ra, rb;

        rst = 1'b1; start = 1'b0; op = 2'b00; shift = 2'd0; sat_en = 1'b0;
        src1 = 16'h0000; src0 = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dst",  32'(dst),  32'h0000);
        check("rst_ovf",  32'(ovf),  32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("add_sat",  2'b00, 2'd1, 1'b1, 16'h0500, 16'h0400, {1'b0, 16'h07FF} | 17'h10000, 0, 0);
        run_op("sub_sat",  2'b01, 2'd2, 1'b1, 16'h0010, 16'h0008, {1'b0, 16'hFFF0}, 0, 0);
        run_op("mul_pos",  2'b10, 2'd0, 1'b0, 16'h2000, 16'h1800, {1'b0, 16'h3000}, 0, 0);
        run_op("mul_min",  2'b10, 2'd0, 1'b0, 16'h8000, 16'h8000, {1'b1, 16'h7FFF}, 0, 0);
`ifdef PARAM_ALU_MUL_ROUND_EN
        run_op("mul_rnd",  2'b10, 2'd0, 1'b0, 16'hFFFF, 16'h0800, {1'b0, 16'h0000}, 0, 0);
`else
        run_op("mul_rnd",  2'b10, 2'd0, 1'b0, 16'hFFFF, 16'h0800, {1'b0, 16'hFFFF}, 0, 0);
`endif
        run_op("add_wrap", 2'b00, 2'd0, 1'b0, 16'h7000, 16'h2000, {1'b1, 16'h9000}, 0, 0);
        run_op("sub_wrap", 2'b01, 2'd2, 1'b0, 16'h8000, 16'h0001, model(2'b01, 2'd2, 1'b0, 16'h8000, 16'h0001), 0, 0);
        run_op("pass_sat", 2'b11, 2'd0, 1'b1, 16'h1234, 16'h5555, {1'b1, 16'h07FF}, 0, 0);
        run_op("pass_raw", 2'b11, 2'd0, 1'b0, 16'h8765, 16'h5555, {1'b0, 16'h8765}, 0, 0);
        run_op("add_sh3",  2'b00, 2'd3, 1'b1, 16'h0100, 16'h0100, {1'b0, 16'h0200}, 0, 0);
        run_op("mul_neg",  2'b10, 2'd0, 1'b0, 16'hFE00, 16'h0300, model(2'b10, 2'd0, 1'b0, 16'hFE00, 16'h0300), 0, 0);
        run_op("mul_big",  2'b10, 2'd0, 1'b0, 16'h7FFF, 16'h7FFF, {1'b1, 16'h7FFF}, 0, 0);
        run_op("mul_lo",   2'b10, 2'd0, 1'b0, 16'h8000, 16'h7FFF, {1'b1, 16'h8000}, 0, 0);

        // Result must hold while idle inputs wiggle.
        repeat (5) begin
            @(negedge clk);
            src1 = 16'($urandom); src0 = 16'($urandom); op = 2'($urandom);
        end
        @(posedge clk); #1;
        check("hold_dst", 32'(dst), 32'h8000);
        check("hold_ovf", 32'(ovf), 32'd1);

        run_op("mul_inj",  2'b10, 2'd0, 1'b0, 16'h2000, 16'h1800, {1'b0, 16'h3000}, 5, 0);
        run_op("mul_rst",  2'b10, 2'd0, 1'b0, 16'h4000, 16'h4000, 17'h00000, 0, 8);
        run_op("post_rst", 2'b00, 2'd0, 1'b0, 16'h0001, 16'h0002, {1'b0, 16'h0003}, 0, 0);

        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(3, 0));
            rs = 2'($urandom_range(3, 0));
            re = 1'($urandom_range(1, 0));
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_op("rand", ro, rs, re, ra, rb, model(ro, rs, re, ra, rb), 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
